// File: rtl/display_scan_ctrl.sv
// ============================================================================
// Module   : display_scan_ctrl
// Purpose  : Wishbone-controlled four-digit seven-segment scan controller with
//            blanking gaps; optional decimal points under DISPLAY_DP_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module display_scan_ctrl #(
    parameter logic [15:0] DIV_RESET    = 16'd49999,
    parameter int unsigned BLANK_CYCLES = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic [3:0]  bcd,
    output logic [3:0]  an_n,
    output logic        dp_n
);

    localparam logic [15:0] C_BLANK_LOAD = 16'(BLANK_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BLANK = 2'd1,
        S_ON    = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Wishbone register file
    // ------------------------------------------------------------------
    logic        r_ack;
    logic [31:0] r_dat;
    logic [15:0] r_data;
    logic        r_en;
    logic [3:0]  r_mask;
    logic [15:0] r_div;
    logic [31:0] w_rdata;
    logic [3:0]  w_dpm;
    logic        w_req;
    logic        w_acc;
    logic        w_wr;
    logic        w_unused;

    assign w_req    = wb_cyc_i & wb_stb_i;
    assign w_acc    = w_req & ~r_ack;   // held requests alternate ack/idle
    assign w_wr     = w_acc & wb_we_i;
    assign wb_ack_o = r_ack;
    assign wb_dat_o = r_dat;
    assign w_unused = ^{wb_dat_i[31:16], wb_adr_i[1:0], wb_sel_i[3:2]};

`ifdef DISPLAY_DP_EN
    logic [3:0] r_dpm;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_dpm <= 4'h0;
        end else if (w_wr && wb_adr_i[3:2] == 2'd1 && wb_sel_i[1]) begin
            r_dpm <= wb_dat_i[11:8];
        end
    end

    assign w_dpm = r_dpm;
`else
    assign w_dpm = 4'h0;
`endif

    always_comb begin
        w_rdata = 32'h0;
        case (wb_adr_i[3:2])
            2'd0:    w_rdata = {16'h0, r_data};
            2'd1:    w_rdata = {20'h0, w_dpm, r_mask, 3'b000, r_en};
            2'd2:    w_rdata = {16'h0, r_div};
            default: w_rdata = 32'h0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ack  <= 1'b0;
            r_dat  <= 32'h0;
            r_data <= 16'h0;
            r_en   <= 1'b0;
            r_mask <= 4'hF;
            r_div  <= DIV_RESET;
        end else begin
            r_ack <= w_acc;
            r_dat <= w_acc ? w_rdata : 32'h0;
            if (w_wr) begin
                case (wb_adr_i[3:2])
                    2'd0: begin
                        if (wb_sel_i[0]) r_data[7:0]  <= wb_dat_i[7:0];
                        if (wb_sel_i[1]) r_data[15:8] <= wb_dat_i[15:8];
                    end
                    2'd1: begin
                        if (wb_sel_i[0]) begin
                            r_en   <= wb_dat_i[0];
                            r_mask <= wb_dat_i[7:4];
                        end
                    end
                    2'd2: begin
                        if (wb_sel_i[0]) r_div[7:0]  <= wb_dat_i[7:0];
                        if (wb_sel_i[1]) r_div[15:8] <= wb_dat_i[15:8];
                    end
                    default: ;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Scan FSM
    // ------------------------------------------------------------------
    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_idx;
    logic [1:0]  w_idx_nxt;
    logic [15:0] r_cnt;
    logic [15:0] w_cnt_nxt;
    logic [3:0]  r_bcd;
    logic [3:0]  w_bcd_nxt;
    logic        r_dp_n;
    logic        w_dp_n_nxt;
    logic [1:0]  w_load_idx;
    logic [3:0]  w_load_bcd;
    logic [3:0]  w_an_n;

    // Digit whose value is loaded on the next BLANK entry.
    assign w_load_idx = (r_state == S_ON) ? r_idx + 2'd1 : 2'd0;

    always_comb begin
        w_load_bcd = 4'h0;
        case (w_load_idx)
            2'd0:    w_load_bcd = r_data[3:0];
            2'd1:    w_load_bcd = r_data[7:4];
            2'd2:    w_load_bcd = r_data[11:8];
            default: w_load_bcd = r_data[15:12];
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = r_cnt;
        w_bcd_nxt   = r_bcd;
        w_dp_n_nxt  = r_dp_n;
        w_an_n      = 4'hF;

        if (!r_en) begin
            w_state_nxt = S_IDLE;
            w_idx_nxt   = 2'd0;
            w_cnt_nxt   = 16'h0;
            w_bcd_nxt   = 4'h0;
            w_dp_n_nxt  = 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_nxt = S_BLANK;
                    w_idx_nxt   = 2'd0;
                    w_cnt_nxt   = C_BLANK_LOAD;
                    w_bcd_nxt   = w_load_bcd;
                    w_dp_n_nxt  = ~w_dpm[w_load_idx];
                end
                S_BLANK: begin
                    if (r_cnt == 16'h0) begin
                        w_state_nxt = S_ON;
                        w_cnt_nxt   = r_div;
                    end else begin
                        w_cnt_nxt = r_cnt - 16'd1;
                    end
                end
                S_ON: begin
                    // Masked digits still consume their slot for uniform brightness.
                    if (r_mask[r_idx]) w_an_n[r_idx] = 1'b0;
                    if (r_cnt == 16'h0) begin
                        w_state_nxt = S_BLANK;
                        w_idx_nxt   = w_load_idx;
                        w_cnt_nxt   = C_BLANK_LOAD;
                        w_bcd_nxt   = w_load_bcd;
                        w_dp_n_nxt  = ~w_dpm[w_load_idx];
                    end else begin
                        w_cnt_nxt = r_cnt - 16'd1;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_idx   <= 2'd0;
            r_cnt   <= 16'h0;
            r_bcd   <= 4'h0;
            r_dp_n  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bcd   <= w_bcd_nxt;
            r_dp_n  <= w_dp_n_nxt;
        end
    end

    assign an_n = w_an_n;
    assign bcd  = r_bcd;

`ifdef DISPLAY_DP_EN
    assign dp_n = r_dp_n;
`else
    assign dp_n = 1'b1;
`endif

endmodule

`default_nettype wire

// File: tb/tb_display_scan_ctrl.sv
// ============================================================================
// Module   : tb_display_scan_ctrl
// Purpose  : Self-checking bench for display_scan_ctrl (register vectors plus
//            scan-timing sequences against an independent slot model).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_display_scan_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_we_i;
    logic [3:0]  wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic [3:0]  bcd;
    logic [3:0]  an_n;
    logic        dp_n;

    int n_checks = 0;
    int n_errors = 0;

`ifdef DISPLAY_DP_EN
    localparam logic [31:0] C_CTRL_DP4F0 = 32'h4F0;
    localparam logic [31:0] C_CTRL_DP4F1 = 32'h4F1;
    localparam logic [3:0]  C_DPM        = 4'b0100;
`else
    localparam logic [31:0] C_CTRL_DP4F0 = 32'h0F0;
    localparam logic [31:0] C_CTRL_DP4F1 = 32'h0F1;
    localparam logic [3:0]  C_DPM        = 4'b0000;
`endif

    display_scan_ctrl #(
        .DIV_RESET    (16'd49999),
        .BLANK_CYCLES (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .wb_cyc_i (wb_cyc_i),
        .wb_stb_i (wb_stb_i),
        .wb_we_i  (wb_we_i),
        .wb_adr_i (wb_adr_i),
        .wb_dat_i (wb_dat_i),
        .wb_sel_i (wb_sel_i),
        .wb_dat_o (wb_dat_o),
        .wb_ack_o (wb_ack_o),
        .bcd      (bcd),
        .an_n     (an_n),
        .dp_n     (dp_n)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [3:0]  adr;
        logic        we;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wb_xfer(input logic [3:0] adr, input logic we, input logic [31:0] dat,
                           input logic [3:0] sel, output logic [31:0] rd);
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = we;
        wb_adr_i = adr;
        wb_dat_i = dat;
        wb_sel_i = sel;
        step();
        chk("ack_latency", {31'h0, wb_ack_o}, 32'h1);
        rd       = wb_dat_o;
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
    endtask

    task automatic wr(input logic [3:0] adr, input logic [31:0] dat);
        logic [31:0] dummy;
        wb_xfer(adr, 1'b1, dat, 4'hF, dummy);
    endtask

    // Cycles from the current sample until the first lit anode.
    task automatic count_to_low(input string name, input int exp);
        int k = 0;
        while (an_n == 4'hF && k < 200) begin
            step();
            k++;
        end
        chk(name, k, exp);
    endtask

    // Advance to the first sample where an_n == pat after an all-off sample.
    task automatic wait_onset(input string name, input logic [3:0] pat);
        logic [3:0] prev = an_n;
        int found = 0;
        for (int i = 0; i < 200 && found == 0; i++) begin
            step();
            if (an_n == pat && prev == 4'hF) found = 1;
            prev = an_n;
        end
        chk(name, found, 1);
    endtask

    // Starting on the first ON cycle of start_slot, compare every cycle
    // against the slot model: on_len lit cycles then 8 blank cycles per digit.
    task automatic check_scan(input string name, input int start_slot, input logic [3:0] mask,
                              input logic [3:0] dpm, input int on_len, input int ncyc);
        int bad = 0;
        int slot_len = 8 + on_len;
        for (int t = 0; t < ncyc; t++) begin
            int slot = (start_slot + t / slot_len) % 4;
            int pos  = t % slot_len;
            int nxt  = (slot + 1) % 4;
            logic [3:0] ea;
            logic [3:0] eb;
            logic       ed;
            if (pos < on_len) begin
                ea = mask[slot] ? ~(4'b0001 << slot) : 4'hF;
                eb = 4'(slot + 1);
                ed = ~dpm[slot];
            end else begin
                ea = 4'hF;
                eb = 4'(nxt + 1);
                ed = ~dpm[nxt];
            end
            if ({an_n, bcd, dp_n} !== {ea, eb, ed}) begin
                if (bad == 0)
                    $display("  %s first difference at t=%0d: an_n=%b bcd=%0d dp_n=%b, model an_n=%b bcd=%0d dp_n=%b",
                             name, t, an_n, bcd, dp_n, ea, eb, ed);
                bad++;
            end
            step();
        end
        chk(name, bad, 0);
    endtask

    initial begin
        logic [31:0] rd;
        logic [3:0]  acks;
        int          n;

        vecs[0]  = '{"rst_data",   4'h0, 1'b0, 32'h0,        4'hF, 32'h0};
        vecs[1]  = '{"rst_ctrl",   4'h4, 1'b0, 32'h0,        4'hF, 32'hF0};
        vecs[2]  = '{"rst_div",    4'h8, 1'b0, 32'h0,        4'hF, 32'hC34F};
        vecs[3]  = '{"rst_reg3",   4'hC, 1'b0, 32'h0,        4'hF, 32'h0};
        vecs[4]  = '{"wr_reg3",    4'hC, 1'b1, 32'hFFFFFFFF, 4'hF, 32'h0};
        vecs[5]  = '{"reg3_ro",    4'hC, 1'b0, 32'h0,        4'hF, 32'h0};
        vecs[6]  = '{"wr_data",    4'h0, 1'b1, 32'h00004321, 4'hF, 32'h0};
        vecs[7]  = '{"wr_data_b1", 4'h0, 1'b1, 32'h0000AB99, 4'h2, 32'h0};
        vecs[8]  = '{"data_sel",   4'h0, 1'b0, 32'h0,        4'hF, 32'hAB21};
        vecs[9]  = '{"wr_data2",   4'h0, 1'b1, 32'hFFFF4321, 4'hF, 32'h0};
        vecs[10] = '{"data_rd",    4'h0, 1'b0, 32'h0,        4'hF, 32'h4321};
        vecs[11] = '{"wr_div",     4'h8, 1'b1, 32'hFFFF0003, 4'hF, 32'h0};
        vecs[12] = '{"div_rd",     4'h8, 1'b0, 32'h0,        4'hF, 32'h3};
        vecs[13] = '{"wr_ctrl_dp", 4'h4, 1'b1, 32'h000004F0, 4'hF, 32'h0};
        vecs[14] = '{"ctrl_dp_rd", 4'h4, 1'b0, 32'h0,        4'hF, C_CTRL_DP4F0};
        vecs[15] = '{"wr_ctrl_0",  4'h4, 1'b1, 32'h000000F0, 4'hF, 32'h0};

        reset    = 1'b1;
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        wb_adr_i = 4'h0;
        wb_dat_i = 32'h0;
        wb_sel_i = 4'h0;
        repeat (3) step();
        chk("rst_an_n", {28'h0, an_n}, 32'hF);
        chk("rst_bcd",  {28'h0, bcd},  32'h0);
        chk("rst_dp_n", {31'h0, dp_n}, 32'h1);
        chk("rst_ack",  {31'h0, wb_ack_o}, 32'h0);
        chk("rst_dat_o", wb_dat_o, 32'h0);
        reset = 1'b0;
        step();

        for (int i = 0; i < 16; i++) begin
            wb_xfer(vecs[i].adr, vecs[i].we, vecs[i].dat, vecs[i].sel, rd);
            if (!vecs[i].we) chk(vecs[i].name, rd, vecs[i].exp);
            step();
            chk("ack_one_cycle", {31'h0, wb_ack_o}, 32'h0);
        end
        chk("an_n_disabled", {28'h0, an_n}, 32'hF);

        // Held request: acked on alternate cycles.
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_adr_i = 4'h0;
        for (int i = 0; i < 4; i++) begin
            step();
            acks[i] = wb_ack_o;
        end
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        chk("held_ack_pattern", {28'h0, acks}, 32'h5);
        step();

        // Enable with DIV=3: first anode 9 cycles after the ack edge, 48-cycle period.
        wr(4'h4, 32'h000000F1);
        count_to_low("first_low_latency", 9);
        check_scan("scan_full", 0, 4'hF, 4'h0, 4, 96);

        wr(4'h4, 32'h000000A1);
        wait_onset("mask_sync", 4'b1101);
        check_scan("scan_mask_a", 1, 4'hA, 4'h0, 4, 96);

        // Clear EN during digit 2's ON window, then re-enable.
        wr(4'h4, 32'h000000F1);
        wait_onset("dig2_sync", 4'b1011);
        wr(4'h4, 32'h000000F0);
        step();
        chk("en_clear_an_n", {28'h0, an_n}, 32'hF);
        chk("en_clear_bcd",  {28'h0, bcd},  32'h0);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (an_n !== 4'hF) n++;
        end
        chk("idle_dark", n, 0);
        wr(4'h4, 32'h000000F1);
        count_to_low("reenable_latency", 9);
        chk("reenable_digit0", {24'h0, an_n, bcd}, {24'h0, 4'b1110, 4'd1});

        // DIV=1 written during digit 0's ON: it keeps 4 cycles, later digits get 2.
        wr(4'h8, 32'h00000001);
        n = 0;
        while (an_n == 4'b1110 && n < 20) begin
            n++;
            step();
        end
        chk("div_mid_on_remaining", n, 3);
        wait_onset("div1_sync", 4'b1101);
        check_scan("scan_div1", 1, 4'hF, 4'h0, 2, 80);

        // DIV=0: single-cycle on-time.
        wr(4'h8, 32'h00000000);
        wait_onset("div0_sync", 4'b1011);
        check_scan("scan_div0", 2, 4'hF, 4'h0, 1, 36);

        // Decimal points.
        wr(4'h4, 32'h000004F1);
        wait_onset("dp_sync", 4'b1110);
        check_scan("scan_dp", 0, 4'hF, C_DPM, 1, 36);
        wb_xfer(4'h4, 1'b0, 32'h0, 4'hF, rd);
        chk("ctrl_dp_readback", rd, C_CTRL_DP4F1);
        step();

        // Reset during a pending request aborts it.
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_adr_i = 4'h4;
        reset    = 1'b1;
        step();
        chk("rst_mid_ack",  {31'h0, wb_ack_o}, 32'h0);
        chk("rst_mid_an_n", {28'h0, an_n}, 32'hF);
        chk("rst_mid_bcd",  {28'h0, bcd}, 32'h0);
        chk("rst_mid_dp_n", {31'h0, dp_n}, 32'h1);
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        reset    = 1'b0;
        step();
        wb_xfer(4'h4, 1'b0, 32'h0, 4'hF, rd);
        chk("rst_mid_ctrl", rd, 32'hF0);
        step();
        wb_xfer(4'h8, 1'b0, 32'h0, 4'hF, rd);
        chk("rst_mid_div", rd, 32'hC34F);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/display_scan_ctrl.md
# display_scan_ctrl

Wishbone-controlled scan controller for the four-digit, common-anode seven-segment display in the `wb_display` subsystem. It holds four BCD digits written by the LM32 and time-multiplexes them through a single external BCD-to-segment decoder. It drives that decoder's `bcd` input plus the active-low digit anodes, inserting a blanking gap at every digit change to prevent ghosting.

## Interface
Parameters:
- `DIV_RESET`, 16'd49999: reset value of the refresh divider; each digit's on-time is DIV+1 cycles.
- `BLANK_CYCLES`, 8: anodes-off cycles before each digit's on-time (≥1).

Ports:
- `clk`  in  1  system clock; everything is synchronous to its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `wb_cyc_i`  in  1  Wishbone cycle.
- `wb_stb_i`  in  1  Wishbone strobe.
- `wb_we_i`  in  1  write enable.
- `wb_adr_i`  in  4  byte address; bits [3:2] select the register.
- `wb_dat_i`  in  32  write data.
- `wb_sel_i`  in  4  byte selects.
- `wb_dat_o`  out  32  read data.
- `wb_ack_o`  out  1  transfer acknowledge.
- `bcd`  out  4  nibble presented to the external decoder.
- `an_n`  out  4  digit anodes, active low; bit i is digit i.
- `dp_n`  out  1  decimal point, active low.

## Operation
Registers (unwritten bits read 0):
- 0x0 DATA[15:0]: digit i = bits [4i+3:4i]. Reset 0.
- 0x4 CTRL: bit0 EN; [7:4] digit mask (1 = shown); [11:8] DP mask (macro only). Reset EN=0, mask=4'hF, DP=0.
- 0x8 DIV[15:0]. Reset DIV_RESET.
- 0xC: reads 0, writes ignored.

Wishbone rules:
- A request (cyc&stb) with ack low gets `wb_ack_o`=1 on the next cycle, for one cycle only.
- A held request is acked every other cycle.
- Write takes effect on the ack edge, honouring `wb_sel_i` per byte.
- `wb_dat_o` is registered and valid while ack is high.

Scan FSM, with a digit index `idx` (2 bits) and a down-counter `cnt` (16 bits):
- IDLE: `an_n`=4'hF, `bcd`=0, `dp_n`=1. EN=1 → BLANK with idx=0, cnt=BLANK_CYCLES-1.
- BLANK: `an_n`=4'hF. `bcd` and `dp_n` already show digit idx; they are loaded on entry. When cnt=0 → ON with cnt=DIV (sampled here).
- ON: `an_n`[idx]=0 if mask[idx]=1, else all ones. The slot is still consumed, so brightness stays uniform. When cnt=0 → BLANK with idx=idx+1 (3 wraps to 0); the next digit's bcd/dp load on that edge.
- EN cleared in any state → IDLE on the next edge; `an_n`=4'hF from that cycle on.
- DATA writes show up at the next BLANK entry. DIV writes apply from the next ON entry. Mask writes apply immediately.
- DIV=0 gives a 1-cycle on-time, which is legal.

## Timing
- Reset (sync, dominant over Wishbone and FSM): `wb_ack_o`=0, `wb_dat_o`=0, `an_n`=4'hF, `bcd`=0, `dp_n`=1, FSM=IDLE, idx=0, cnt=0.
- Reset mid-scan or mid-transfer aborts everything; a pending request is not acked.
- Ack latency: 1 cycle.
- From the edge that writes EN=1 to the first `an_n` low: BLANK_CYCLES+1 cycles.
- Full scan period: 4·(BLANK_CYCLES+DIV+1) cycles.
- `bcd` is stable for BLANK_CYCLES cycles before and throughout its anode-low window.
- No two anode bits are ever low at once, and `an_n` never goes from one digit's low straight to another's.

## Configuration
- `DISPLAY_DP_EN` defined:
  - CTRL[11:8] is writable and readable.
  - `dp_n` = ~DP[idx], loaded with `bcd` at BLANK entry.
- Undefined:
  - CTRL[11:8] reads 0 and writes are ignored.
  - `dp_n` is tied to 1.
  - No DP storage is synthesized.

## Test plan
- Reset, then read 0x0/0x4/0x8 → 0x0, 0xF0, DIV_RESET; `an_n`=4'hF; ack exactly 1 cycle after stb.
- Write DATA=0x4321, DIV=3, CTRL=0xF1 (BLANK_CYCLES=8) → first anode low 9 cycles after the ack edge. Expected sequence:
  - `an_n`=1110 with bcd=1 for 4 cycles, then 8 cycles of 1111.
  - Then 1101 with bcd=2, then 1011/3 and 0111/4.
  - Then back to 1110/1; period 48 cycles.
- CTRL=0xA1 (mask 1010) → digits 0 and 2 are never lit; slot timing is unchanged (period still 48).
- Clear EN during digit 2's ON → `an_n`=4'hF on the next cycle and FSM in IDLE; re-enable → restarts at digit 0 after 9 cycles.
- Write DIV=1 mid-ON (old DIV=3) → the current digit still gets 4 cycles; following digits get 2 cycles.
- With `DISPLAY_DP_EN`, CTRL=0x4F1 → `dp_n`=0 only while idx=2. Without the macro, CTRL reads back 0xF1 and `dp_n` stays 1.
